cic_decim: RTL and testbench

Fixed-order cascaded integrator-comb (CIC) decimator for the DDC datapath. It integrates every qualified input sample at the input rate and runs the comb section only on an externally supplied decimation strobe, so the decimation ratio is set entirely by the strobe cadence, up to MAXRATE. It emits one truncated output word per strobe, with a one-cycle valid pulse.

---
 rtl/cic_decim.sv | 106 ++++++++++
 tb/tb_cic_decim.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim.sv
// rtl/cic_decim.sv - strobe-decimated cascaded integrator-comb filter
module cic_decim #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16,
    parameter int NUM_STAGES    = 5,
    parameter int DIFF_DELAY    = 1,
    parameter int MAXRATE       = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [DATAIN_WIDTH-1:0]  data_i,
    input  logic                     act_i,
    input  logic                     act_out_i,
    output logic [DATAOUT_WIDTH-1:0] data_o,
    output logic                     val_o
);

    localparam int GROWTH = $clog2(MAXRATE * DIFF_DELAY);
    localparam int W      = DATAIN_WIDTH + NUM_STAGES * GROWTH;

    logic [W-1:0] int_q  [NUM_STAGES];
    logic [W-1:0] int_d  [NUM_STAGES];
    logic [W-1:0] comb_q [NUM_STAGES];
    logic [W-1:0] comb_d [NUM_STAGES];
    logic [W-1:0] dly_q  [NUM_STAGES][DIFF_DELAY];
    logic [W-1:0] dly_d  [NUM_STAGES][DIFF_DELAY];
    logic [W-1:0] comb_in [NUM_STAGES];
    logic [W-1:0] data_ext;

    logic                     fire_q, fire_d;
    logic [DATAOUT_WIDTH-1:0] data_q, data_d;
    logic                     val_q, val_d;

    assign data_ext = W'($signed(data_i));

    // Next state for integrators, combs and the output stage; everything holds while en_i is low.
    always_comb begin
        int_d  = int_q;
        comb_d = comb_q;
        dly_d  = dly_q;
        fire_d = fire_q;
        data_d = data_q;
        val_d  = 1'b0;

        // Comb inputs are the registered value of the previous stage (pipelined combs);
        // the first comb samples the last integrator before this cycle's integration.
        comb_in[0] = int_q[NUM_STAGES-1];
        for (int k = 1; k < NUM_STAGES; k++) begin
            comb_in[k] = comb_q[k-1];
        end

        if (en_i) begin
            if (act_i) begin
                int_d[0] = int_q[0] + data_ext;
                for (int k = 1; k < NUM_STAGES; k++) begin
                    int_d[k] = int_q[k] + int_q[k-1];
                end
            end

            if (act_out_i) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    comb_d[k]   = comb_in[k] - dly_q[k][DIFF_DELAY-1];
                    dly_d[k][0] = comb_in[k];
                    for (int d = 1; d < DIFF_DELAY; d++) begin
                        dly_d[k][d] = dly_q[k][d-1];
                    end
                end
            end

            // One cycle after a comb update the truncated result is presented with a valid pulse.
            fire_d = act_out_i;
            val_d  = fire_q;
            if (fire_q) begin
                data_d = comb_q[NUM_STAGES-1][W-1 -: DATAOUT_WIDTH];
            end
        end
    end

    // State registers with synchronous active-low reset that discards all filter history.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                int_q[k]  <= '0;
                comb_q[k] <= '0;
                for (int d = 0; d < DIFF_DELAY; d++) begin
                    dly_q[k][d] <= '0;
                end
            end
            fire_q <= 1'b0;
            data_q <= '0;
            val_q  <= 1'b0;
        end else begin
            int_q  <= int_d;
            comb_q <= comb_d;
            dly_q  <= dly_d;
            fire_q <= fire_d;
            data_q <= data_d;
            val_q  <= val_d;
        end
    end

    assign data_o = data_q;
    assign val_o  = val_q;

endmodule

// File: tb/tb_cic_decim.sv
// tb/tb_cic_decim.sv - randomized and directed self-checking bench for cic_decim
module tb_cic_decim;

    localparam int DW = 16;
    localparam int N  = 5;
    localparam int M  = 1;
    localparam int MR = 8;
    localparam int W  = DW + N * $clog2(MR * M);
    localparam int SH = W - DW;
    localparam longint MASK = (longint'(1) << W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        act;
    logic        act_out;
    logic [15:0] din;
    logic [15:0] dout;
    logic        val;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cic_decim #(
        .DATAIN_WIDTH (DW),
        .DATAOUT_WIDTH(DW),
        .NUM_STAGES   (N),
        .DIFF_DELAY   (M),
        .MAXRATE      (MR)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .en_i     (en),
        .data_i   (din),
        .act_i    (act),
        .act_out_i(act_out),
        .data_o   (dout),
        .val_o    (val)
    );

    // Reference model: integrator cascade as running sums, decimated sequence s[j] kept in a
    // queue, and the comb section expressed as the binomial N-th difference delayed N-1 strobes.
    longint      integ [N];
    longint      hist [$];
    bit          pend;
    longint      pend_raw;
    logic [15:0] exp_data;
    bit          exp_val;
    longint      raw_sum;

    bit          rec1, rec2;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    function automatic longint sgn(input longint v);
        return v[W-1] ? v - (longint'(1) << W) : v;
    endfunction

    function automatic longint comb_out(input int j);
        longint acc  = 0;
        longint coef = 1;
        int     m    = j - (N - 1);
        for (int i = 0; i <= N; i++) begin
            int idx = m - i * M;
            if (idx >= 0) begin
                if (i % 2 == 0) acc += coef * hist[idx];
                else            acc -= coef * hist[idx];
            end
            coef = coef * (N - i) / (i + 1);
        end
        return acc & MASK;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) integ[k] = 0;
        hist.delete();
        pend     = 1'b0;
        pend_raw = 0;
        exp_data = '0;
        exp_val  = 1'b0;
        raw_sum  = 0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_clear();
        end else if (!en) begin
            exp_val = 1'b0;
        end else begin
            exp_val = pend;
            if (pend) exp_data = pend_raw[SH +: 16];
            pend = act_out;
            if (act_out) begin
                hist.push_back(integ[N-1]);
                pend_raw = comb_out(hist.size() - 1);
                raw_sum += sgn(pend_raw);
            end
            if (act) begin
                for (int k = N - 1; k >= 1; k--) integ[k] = (integ[k] + integ[k-1]) & MASK;
                integ[0] = (integ[0] + longint'($signed(din))) & MASK;
            end
        end
    endtask

    task automatic check(input string nm, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic a, input logic ao,
                         input logic [15:0] d);
        rst_n   = r;
        en      = e;
        act     = a;
        act_out = ao;
        din     = d;
        @(posedge clk);
        model_step();
        #1;
        check("val_o", longint'(val), longint'(exp_val));
        check("data_o", longint'(dout), longint'(exp_data));
        if (rec1 && exp_val) q1.push_back(exp_data);
        if (rec2 && val)     q2.push_back(dout);
    endtask

    // Regular schedule: act_i every other clock, act_out_i on every 8th act_i (coinciding with it).
    // imp >= 0 turns the input into a unit impulse at that act index; an en_i low window is optional.
    task automatic stream(input logic [15:0] v, input int ncyc, input int imp,
                          input int lo_start, input int lo_len);
        int acts = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic        a  = (c % 2 == 0);
            logic        ao = a && ((c / 2) % 8 == 7);
            logic        e  = !(c >= lo_start && c < lo_start + lo_len);
            logic [15:0] d  = (imp < 0) ? v : ((a && acts == imp) ? 16'd1 : 16'd0);
            cycle(1'b1, e, a, ao, d);
            if (a) acts++;
            if (!e) begin
                check("en_low_val", longint'(val), 0);
                check("en_low_hold", longint'(dout), 1000);
            end
        end
    endtask

    initial begin
        longint imp_total = 0;
        rec1 = 1'b0;
        rec2 = 1'b0;
        model_clear();

        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            check("reset_data", longint'(dout), 0);
            check("reset_val", longint'(val), 0);
        end

        stream(16'd0, 160, -1, -1, 0);
        check("zero_in_data", longint'(dout), 0);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        rec1 = 1'b1;
        stream(16'd1000, 400, -1, -1, 0);
        rec1 = 1'b0;
        check("dc_pos_settle", longint'(dout), 1000);

        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'd1000);
        rec2 = 1'b1;
        stream(16'd1000, 400, -1, -1, 0);
        rec2 = 1'b0;
        check("restart_count", longint'(q2.size()), longint'(q1.size()));
        for (int i = 0; i < q1.size() && i < q2.size(); i++) begin
            check("restart_seq", longint'(q2[i]), longint'(q1[i]));
        end

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        stream(16'h8000, 400, -1, -1, 0);
        check("dc_neg_settle", longint'(dout), longint'(16'h8000));

        // Impulses at every act phase of the decimation window together collect the full R^N gain.
        for (int p = 0; p < MR; p++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
            stream(16'd0, 300, p, -1, 0);
            imp_total += raw_sum;
        end
        check("impulse_gain", imp_total, 32768);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        stream(16'd1000, 400, -1, 396, 5);
        stream(16'd1000, 400, -1, -1, 0);
        check("en_resume_settle", longint'(dout), 1000);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 399) != 0), 1'($urandom_range(0, 7) != 0),
                  1'($urandom), 1'($urandom_range(0, 5) == 0), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
